serial_adder_seq: RTL and testbench

- Bit-serial add/subtract controller that time-shares one 1-bit adder slice (AND/XOR half-adder pair plus carry flop), one operand bit per clock.
- Captures two 4-bit operands from ui_in on a start edge, runs WIDTH shift cycles, then presents the result, carry and signed overflow on uo_out.
- Sits as a Tiny Tapeout user module alongside the combinational half-adder demo and uses the same tt_um pin frame.

---
 rtl/serial_adder_seq.sv | 92 +++++++++
 tb/tb_serial_adder_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial 4-bit add/subtract on one shared 1-bit full-adder slice
module serial_adder_seq #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic start_q;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, res_q, res_d;
  logic c_q, c_d, c_msb_q, c_msb_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic launch, s, cout, unused;
  assign s      = a_q[0] ^ b_q[0] ^ c_q;
  assign cout   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign launch = uio_in[0] & ~start_q & (state_q != SHIFT);
  assign uo_out  = {ovf_q, state_q == DONE, state_q == SHIFT, carry_q, res_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
  assign unused  = &{1'b0, uio_in[7:2]};
  // State and datapath registers; ena low freezes everything including the start edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      c_msb_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      start_q <= uio_in[0];
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      res_q   <= res_d;
      c_q     <= c_d;
      c_msb_q <= c_msb_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  // Launch loads operands (subtract = A + ~B + 1), SHIFT consumes one bit per edge, last bit commits outputs
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    res_d   = res_q;
    c_d     = c_q;
    c_msb_d = c_msb_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (state_q != SHIFT) begin
      if (launch) begin
        a_d     = ui_in[WIDTH-1:0];
        b_d     = uio_in[1] ? ~ui_in[2*WIDTH-1:WIDTH] : ui_in[2*WIDTH-1:WIDTH];
        c_d     = uio_in[1];
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else begin
      c_d   = cout;
      r_d   = {s, r_q[WIDTH-1:1]};
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      c_msb_d = (cnt_q == CW'(WIDTH - 2)) ? cout : c_msb_q;
      if (cnt_q == CW'(WIDTH - 1)) begin
        res_d   = {s, r_q[WIDTH-1:1]};
        carry_d = cout;
        ovf_d   = c_msb_q ^ cout;
        state_d = DONE;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: randomized and directed checks of serial_adder_seq against an arithmetic model
module tb_serial_adder_seq;
  logic clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [7:0] prev;
  int n_cmp, n_err;

  serial_adder_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic op);
    int ia, ib, sa, sb, sum, ss;
    logic cy, ov;
    ia = int'(a);
    ib = int'(b);
    sa = ia > 7 ? ia - 16 : ia;
    sb = ib > 7 ? ib - 16 : ib;
    sum = op ? ia - ib : ia + ib;
    ss  = op ? sa - sb : sa + sb;
    cy  = op ? (ia >= ib) : (sum > 15);
    ov  = (ss > 7) || (ss < -8);
    return {ov, 1'b1, 1'b0, cy, 4'(sum)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    n_cmp++;
    if (uo_out !== exp) begin
      n_err++;
      $display("FAIL %s: uo_out=%02h expected=%02h at %0t", name, uo_out, exp, $time);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic op, input string name);
    logic [7:0] exp;
    exp = model(a, b, op);
    uio_in = 8'h00;
    tick;
    ui_in  = {b, a};
    uio_in = {6'b0, op, 1'b1};
    tick;
    uio_in = {6'b0, ~op, 1'b0};
    ui_in  = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk({name, "_busy"}, (prev & 8'h9F) | 8'h20);
      tick;
    end
    chk({name, "_done"}, exp);
    prev = exp;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; prev = 8'h00;
    #12;
    chk("reset_uo", 8'h00);
    n_cmp++;
    if ({uio_out, uio_oe} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_uio: got=%04h expected=0000", {uio_out, uio_oe});
    end
    #1 rst_n = 1'b1;
    tick;
    chk("reset_idle", 8'h00);
  endtask

  task automatic test_add;
    run_op(4'd3, 4'd5, 1'b0, "add_3_5");
    chk("add_3_5_val", 8'hC8);
    run_op(4'd15, 4'd1, 1'b0, "add_wrap");
    chk("add_wrap_val", 8'h50);
  endtask

  task automatic test_sub;
    run_op(4'd5, 4'd3, 1'b1, "sub_5_3");
    chk("sub_5_3_val", 8'h52);
    run_op(4'd3, 4'd5, 1'b1, "sub_3_5");
    chk("sub_3_5_val", 8'h4E);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_op(4'($urandom), 4'($urandom), 1'($urandom), "rand");
  endtask

  task automatic test_start_held;
    logic [3:0] a, b;
    logic [7:0] exp;
    a = 4'($urandom); b = 4'($urandom);
    exp = model(a, b, 1'b0);
    uio_in = 8'h00; tick;
    ui_in = {b, a}; uio_in = 8'h01; tick;
    ui_in = 8'($urandom);
    chk("held_e0", (prev & 8'h9F) | 8'h20);
    tick;
    chk("held_e1", (prev & 8'h9F) | 8'h20);
    uio_in = 8'h00; ui_in = 8'($urandom); tick;
    chk("held_e2", (prev & 8'h9F) | 8'h20);
    uio_in = 8'h01; tick;
    chk("held_e3", (prev & 8'h9F) | 8'h20);
    tick;
    chk("held_done", exp);
    for (int i = 0; i < 6; i++) begin
      ui_in = 8'($urandom); tick;
      chk("held_stay", exp);
    end
    prev = exp;
    uio_in = 8'h00;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    exp = model(4'd9, 4'd4, 1'b1);
    uio_in = 8'h00; tick;
    ui_in = 8'h49; uio_in = 8'h03; tick;
    uio_in = 8'h02;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_busy", (prev & 8'h9F) | 8'h20);
      tick;
    end
    chk("b2b_busy3", (prev & 8'h9F) | 8'h20);
    uio_in = 8'h01; ui_in = 8'h11; tick;
    chk("b2b_finish_edge", exp);
    tick;
    chk("b2b_no_relaunch", exp);
    prev = exp;
    run_op(4'd12, 4'd7, 1'b0, "b2b_next");
  endtask

  task automatic test_ena_stall;
    logic [7:0] exp;
    exp = model(4'd7, 4'd2, 1'b0);
    uio_in = 8'h00; tick;
    ui_in = 8'h27; uio_in = 8'h01; tick;
    uio_in = 8'h00;
    chk("ena_e0", (prev & 8'h9F) | 8'h20);
    tick;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uio_in = 8'($urandom); ui_in = 8'($urandom);
      tick;
      chk("ena_frozen", (prev & 8'h9F) | 8'h20);
    end
    ena = 1'b1; uio_in = 8'h00;
    tick;
    chk("ena_e2", (prev & 8'h9F) | 8'h20);
    tick;
    chk("ena_e3", (prev & 8'h9F) | 8'h20);
    tick;
    chk("ena_done", exp);
    chk("ena_val", 8'hC9);
    prev = exp;
  endtask

  task automatic test_async_reset;
    uio_in = 8'h00; tick;
    ui_in = 8'h66; uio_in = 8'h01; tick;
    uio_in = 8'h00;
    tick;
    #2 rst_n = 1'b0;
    #1 chk("arst_immediate", 8'h00);
    #1 rst_n = 1'b1;
    tick;
    chk("arst_after", 8'h00);
    prev = 8'h00;
    run_op(4'd6, 4'd6, 1'b0, "arst_6_6");
    chk("arst_6_6_val", 8'hCC);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset;
    test_add;
    test_sub;
    test_start_held;
    test_back_to_back;
    test_ena_stall;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
